id_ex_stage: RTL
================

# id_ex_stage

Parametrised decode-to-execute pipeline register for the pipelined RV32I core, sitting between the register-file/immediate-extend logic (D) and the ALU/branch logic (E). It carries the control bundle and datapath operands, tracks a valid bit, and inserts bubbles for load-use hazards and taken branches/jumps. It also generates the fetch/decode stall and decode flush strobes and counts inserted bubbles for performance reporting.

## Interface
- `XLEN`, 32: datapath width (operands, PC, immediate).
- `REG_AW`, 5: register address width.
- `CNT_W`, 16: bubble counter width.
- `clk` in 1: single core clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_d` in 1: D holds a real instruction.
- `ctrl_d` in `ctrl_t`: control bundle (reg_write, result_src[1:0], mem_write, jump, branch, alu_control[2:0], alu_src); ImmSrc is consumed in D and not carried.
- `rd1_d`, `rd2_d`, `pc_d`, `imm_ext_d`, `pc_plus4_d` in XLEN: D-stage operands.
- `rs1_d`, `rs2_d`, `rd_d` in REG_AW: source and destination register addresses.
- `pc_src_e` in 1: E resolved taken branch or jump (redirect).
- `valid_e`, `ctrl_e`, `rd1_e`, `rd2_e`, `pc_e`, `imm_ext_e`, `pc_plus4_e`, `rs1_e`, `rs2_e`, `rd_e` out: registered E-stage copies, same widths as the D versions.
- `stall_f`, `stall_d` out 1: hold PC and IF/ID (combinational).
- `flush_d` out 1: clear IF/ID (combinational).
- `bubble_cnt` out CNT_W: saturating count of inserted bubbles.

## Operation
- Load-use detect, combinational: `lu = valid_e & ctrl_e.reg_write & (ctrl_e.result_src == RES_MEM) & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)) & valid_d`.
- `stall_f = stall_d = lu & ~pc_src_e`.
- `flush_d = pc_src_e`.
- Per clock edge, priority high to low:
  - `pc_src_e`: bubble (wrong-path D instruction killed).
  - `lu`: bubble (the D instruction is held upstream and re-presented next cycle).
  - Otherwise: capture all D inputs.
- Bubble means:
  - `valid_e` = 0.
  - Every `ctrl_e` field = 0, so reg_write, mem_write, branch and jump are all deasserted.
  - `rd_e`, `rs1_e`, `rs2_e` = 0.
  - Data fields hold their previous values. They are don't-care and are not required to clear.
- Capturing with `valid_d`=0 also yields `ctrl_e` = 0. Control is gated by valid, so an invalid instruction can never write.
- `bubble_cnt` increments by 1 on each edge that inserts a bubble caused by `lu` or `pc_src_e`. An idle `valid_d`=0 capture does not count. The counter saturates at all-ones.

## Timing
- Latency: D to E is 1 cycle.
- Reset values (async, immediate on `rst` assert):
  - All E outputs 0, including `valid_e`=0 and `ctrl_e`=0.
  - `bubble_cnt`=0.
  - `stall_f`, `stall_d`, `flush_d` = 0, which follows from `valid_e`=0 and `pc_src_e` being driven low by E during reset.
- Reset released mid-stream: the first capture happens on the first rising edge after deassertion.
- Simultaneous `lu` and `pc_src_e`:
  - Redirect wins; stall is suppressed so fetch can take the new PC.
  - Exactly one bubble is inserted and counted once.
- Back-to-back load-use: after one bubble `valid_e`=0, so `lu` cannot repeat on the next cycle. Stall length is exactly 1 cycle.
- `rd_e == 0` never stalls, even for a load to x0.
- `bubble_cnt` at all-ones stays at all-ones. It is not wrapped.

## Structure
- Shared package `core_pkg`:
  - `ctrl_t` packed struct.
  - `result_src` encodings `RES_ALU`=0, `RES_MEM`=1, `RES_PC4`=2.
  - ALU control encodings.
  - `REG_AW` constant.
- Sub-module `hazard_lu`, purely combinational: inputs `rs1_d`, `rs2_d`, `valid_d`, `valid_e`, `ctrl_e`, `rd_e`, `pc_src_e`; outputs `lu`, `stall_f`, `stall_d`, `flush_d`.
- The top level holds the registers and the counter.

## Test plan
- **Reset:** assert `rst` mid-cycle with `valid_d`=1 -> all outputs 0 immediately, with no clock edge needed; after release, the next edge captures `pc_d`=0x100 so `pc_e`=0x100.
- **Plain pass:** lw-independent add, `rd1_d`=5, `rd2_d`=7, reg_write=1 -> one cycle later `rd1_e`=5, `rd2_e`=7, `valid_e`=1; stall outputs stay 0.
- **Load-use:**
  - E holds lw x5 (reg_write=1, result_src=RES_MEM); D holds add with `rs1_d`=x5.
  - Expect `stall_f`=`stall_d`=1 for one cycle, the next `valid_e`=0 with `ctrl_e`=0, and `bubble_cnt`=1.
  - The add then enters E on the following edge.
- **x0 load:** E holds lw x0 and D reads x0 -> no stall; the D instruction is captured normally.
- **Branch plus load-use together:** `pc_src_e`=1 while `lu`=1 -> `stall_f`=0, `flush_d`=1, one bubble, `bubble_cnt` +1 (not +2).
- **Saturation:** with `CNT_W`=4, force 20 redirects -> `bubble_cnt` reads 15 after the 15th and stays at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and encodings for the pipelined RV32I core.
// The control bundle travels between stages as one packed struct.
package core_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_MEM = 2'd1,
      RES_PC4 = 2'd2
   } result_src_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   // ImmSrc is consumed in decode, so it is not part of the carried bundle.
   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      alu_ctrl_t   alu_control;
      logic        alu_src;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_lu.sv
// Combinational load-use detection and fetch/decode stall/flush strobes.
module hazard_lu
   import core_pkg::*;
#(
   parameter int REG_AW = core_pkg::REG_AW
) (
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              valid_e,
   input  ctrl_t             ctrl_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              pc_src_e,
   output logic              lu,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d
);

   logic w_load_e;
   logic w_match;

   assign w_load_e = valid_e & ctrl_e.reg_write & (ctrl_e.result_src == RES_MEM);
   assign w_match  = (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
   assign lu       = w_load_e & w_match & valid_d;

   // A redirect kills the stalled instruction anyway, so fetch must move on.
   assign stall_f = lu & ~pc_src_e;
   assign stall_d = lu & ~pc_src_e;
   assign flush_d = pc_src_e;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with bubble insertion for load-use
// hazards and redirects, plus a saturating bubble counter.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = core_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  ctrl_t             ctrl_d,
   input  logic [XLEN-1:0]   rd1_d,
   input  logic [XLEN-1:0]   rd2_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   imm_ext_d,
   input  logic [XLEN-1:0]   pc_plus4_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              pc_src_e,
   output logic              valid_e,
   output ctrl_t             ctrl_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   imm_ext_e,
   output logic [XLEN-1:0]   pc_plus4_e,
   output logic [REG_AW-1:0] rs1_e,
   output logic [REG_AW-1:0] rs2_e,
   output logic [REG_AW-1:0] rd_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              w_lu;
   logic              w_bubble;
   logic              r_valid;
   ctrl_t             r_ctrl;
   logic [XLEN-1:0]   r_rd1;
   logic [XLEN-1:0]   r_rd2;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_imm_ext;
   logic [XLEN-1:0]   r_pc_plus4;
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic [REG_AW-1:0] r_rd;
   logic [CNT_W-1:0]  r_bubble_cnt;

   hazard_lu #(
      .REG_AW(REG_AW)
   ) u_hazard (
      .valid_d (valid_d),
      .rs1_d   (rs1_d),
      .rs2_d   (rs2_d),
      .valid_e (r_valid),
      .ctrl_e  (r_ctrl),
      .rd_e    (r_rd),
      .pc_src_e(pc_src_e),
      .lu      (w_lu),
      .stall_f (stall_f),
      .stall_d (stall_d),
      .flush_d (flush_d)
   );

   assign w_bubble = pc_src_e | w_lu;

   // Bubbles clear control and register addresses; data fields are left alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_ctrl     <= '0;
         r_rd1      <= '0;
         r_rd2      <= '0;
         r_pc       <= '0;
         r_imm_ext  <= '0;
         r_pc_plus4 <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
      end else if (w_bubble) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
      end else begin
         r_valid    <= valid_d;
         r_ctrl     <= valid_d ? ctrl_d : '0;
         r_rd1      <= rd1_d;
         r_rd2      <= rd2_d;
         r_pc       <= pc_d;
         r_imm_ext  <= imm_ext_d;
         r_pc_plus4 <= pc_plus4_d;
         r_rs1      <= rs1_d;
         r_rs2      <= rs2_d;
         r_rd       <= rd_d;
      end
   end

   // One count per inserted bubble, pinned at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubble_cnt <= '0;
      end else if (w_bubble && (r_bubble_cnt != '1)) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign valid_e    = r_valid;
   assign ctrl_e     = r_ctrl;
   assign rd1_e      = r_rd1;
   assign rd2_e      = r_rd2;
   assign pc_e       = r_pc;
   assign imm_ext_e  = r_imm_ext;
   assign pc_plus4_e = r_pc_plus4;
   assign rs1_e      = r_rs1;
   assign rs2_e      = r_rs2;
   assign rd_e       = r_rd;
   assign bubble_cnt = r_bubble_cnt;

endmodule
